// File: rtl/aes_pkg.sv
// Shared AES decryption definitions: engine states, byte ordering helper and
// GF(2^4)/GF((2^4)^2) arithmetic used by the inverse S-box.
package aes_pkg;

  localparam int         AES_STATE_BYTES  = 16;
  localparam logic [7:0] AES_INV_AFFINE_C = 8'h05;

  // y^2 + y + lambda is irreducible over GF(2^4) with x^4 + x + 1 (trace of 4'hC is 1)
  localparam logic [3:0] GF4_LAMBDA = 4'hC;
  localparam logic [8:0] AES_POLY   = 9'h11B;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } eng_state_e;

  // Byte i occupies [127-8i -: 8]; returns the LSB position of that byte.
  function automatic logic [6:0] byte_lsb(input logic [3:0] idx);
    return 7'd120 - {idx, 3'b000};
  endfunction

  function automatic logic [3:0] gf4_mul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] r;
    logic [3:0] x;
    r = '0;
    x = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) r = r ^ x;
      x = {x[2:0], 1'b0} ^ (x[3] ? 4'h3 : 4'h0);
    end
    return r;
  endfunction

  function automatic logic [3:0] gf4_sq(input logic [3:0] a);
    return gf4_mul(a, a);
  endfunction

  // a^-1 = a^14 in GF(16); maps 0 to 0 naturally.
  function automatic logic [3:0] gf4_inv(input logic [3:0] a);
    logic [3:0] a2;
    logic [3:0] a4;
    logic [3:0] a8;
    a2 = gf4_sq(a);
    a4 = gf4_sq(a2);
    a8 = gf4_sq(a4);
    return gf4_mul(gf4_mul(a8, a4), a2);
  endfunction

  // Composite element {h, l} represents h*y + l with y^2 = y + lambda.
  function automatic logic [7:0] gf8c_mul(input logic [7:0] a, input logic [7:0] b);
    logic [3:0] hh;
    logic [3:0] hi;
    logic [3:0] lo;
    hh = gf4_mul(a[7:4], b[7:4]);
    hi = hh ^ gf4_mul(a[7:4], b[3:0]) ^ gf4_mul(a[3:0], b[7:4]);
    lo = gf4_mul(hh, GF4_LAMBDA) ^ gf4_mul(a[3:0], b[3:0]);
    return {hi, lo};
  endfunction

  // Linear map given as eight 8-bit columns packed LSB-column first.
  function automatic logic [7:0] map_apply(input logic [63:0] m, input logic [7:0] a);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      if (a[i]) r = r ^ m[8*i +: 8];
    end
    return r;
  endfunction

  // Isomorphism into the composite field: column i is alpha^i, where alpha is
  // the first composite-field root of the AES polynomial.
  function automatic logic [63:0] build_map_in();
    logic [63:0] m;
    logic [7:0]  p;
    logic [7:0]  acc;
    logic [7:0]  alpha;
    logic        found;
    m     = '0;
    found = 1'b0;
    for (int c = 0; c < 256; c++) begin
      alpha = 8'(c);
      p     = 8'h01;
      acc   = 8'h00;
      for (int i = 0; i <= 8; i++) begin
        if (AES_POLY[i]) acc = acc ^ p;
        p = gf8c_mul(p, alpha);
      end
      if (acc == 8'h00 && !found) begin
        found = 1'b1;
        p     = 8'h01;
        for (int i = 0; i < 8; i++) begin
          m[8*i +: 8] = p;
          p = gf8c_mul(p, alpha);
        end
      end
    end
    return m;
  endfunction

  // Inverse map: column j is the polynomial-basis byte that maps onto basis bit j.
  function automatic logic [63:0] build_map_out(input logic [63:0] min);
    logic [63:0] m;
    logic [7:0]  v;
    m = '0;
    for (int a = 0; a < 256; a++) begin
      v = map_apply(min, 8'(a));
      for (int j = 0; j < 8; j++) begin
        if (v == (8'h01 << j)) m[8*j +: 8] = 8'(a);
      end
    end
    return m;
  endfunction

  localparam logic [63:0] MAP_IN  = build_map_in();
  localparam logic [63:0] MAP_OUT = build_map_out(MAP_IN);

endpackage

// File: rtl/inv_sbox.sv
// Combinational AES inverse S-box: inverse affine transform, then
// multiplicative inversion through the GF((2^4)^2) composite field.
module inv_sbox
  import aes_pkg::*;
(
  input  logic [7:0] value,
  output logic [7:0] result
);

  logic [7:0] affine;
  logic [7:0] comp;
  logic [3:0] h;
  logic [3:0] l;
  logic [3:0] norm;
  logic [3:0] norm_inv;
  logic [3:0] inv_h;
  logic [3:0] inv_l;

  assign affine = {value[6:0], value[7]} ^ {value[4:0], value[7:5]} ^
                  {value[1:0], value[7:2]} ^ AES_INV_AFFINE_C;

  assign comp = map_apply(MAP_IN, affine);
  assign h    = comp[7:4];
  assign l    = comp[3:0];

  // (h*y + l)^-1 = (h*y + (h ^ l)) / (lambda*h^2 + h*l + l^2)
  assign norm     = gf4_mul(gf4_sq(h), GF4_LAMBDA) ^ gf4_mul(h, l) ^ gf4_sq(l);
  assign norm_inv = gf4_inv(norm);
  assign inv_h    = gf4_mul(h, norm_inv);
  assign inv_l    = gf4_mul(h ^ l, norm_inv);

  assign result = map_apply(MAP_OUT, {inv_h, inv_l});

endmodule

// File: rtl/inv_sub_bytes_engine.sv
// Multi-cycle InvSubBytes: captures a 128-bit state, rewrites BYTES_PER_CYCLE
// bytes in place per RUN cycle, then holds the result until out_ready.
module inv_sub_bytes_engine
  import aes_pkg::*;
#(
  parameter int BYTES_PER_CYCLE = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  localparam int STEPS = AES_STATE_BYTES / BYTES_PER_CYCLE;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

  if (!(BYTES_PER_CYCLE == 1 || BYTES_PER_CYCLE == 2 || BYTES_PER_CYCLE == 4 ||
        BYTES_PER_CYCLE == 8 || BYTES_PER_CYCLE == 16)) begin : g_bad_lanes
    $error("BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  eng_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic [127:0]     st_reg;
  logic [127:0]     st_next;
  logic [3:0]       base;
  logic [3:0]       lane_idx [BYTES_PER_CYCLE];
  logic [7:0]       lane_in  [BYTES_PER_CYCLE];
  logic [7:0]       lane_out [BYTES_PER_CYCLE];

  // With 16 lanes the multiplier constant wraps to 0, which matches cnt staying 0.
  assign base = 4'(cnt) * 4'(BYTES_PER_CYCLE);

  for (genvar k = 0; k < BYTES_PER_CYCLE; k++) begin : g_lane
    assign lane_idx[k] = base + 4'(k);
    assign lane_in[k]  = st_reg[byte_lsb(lane_idx[k]) +: 8];

    inv_sbox u_inv_sbox (
      .value  (lane_in[k]),
      .result (lane_out[k])
    );
  end

  always_comb begin
    st_next = st_reg;
    for (int k = 0; k < BYTES_PER_CYCLE; k++) begin
      st_next[byte_lsb(lane_idx[k]) +: 8] = lane_out[k];
    end
  end

  // Valid/ready: a block moves on an edge where valid and ready are both high;
  // in_ready is high only in IDLE, out_valid only in DONE, and out_state is
  // frozen while out_valid is high and out_ready is low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      st_reg    <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            st_reg   <= in_state;
            cnt      <= '0;
            state    <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          st_reg <= st_next;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  assign out_state = st_reg;

endmodule

// File: tb/tb_inv_sub_bytes_engine.sv
// Directed bench for inv_sub_bytes_engine: brute-force GF(2^8) inverse model,
// scoreboard queue with a per-cycle compare, plus a lane-count sweep.
module tb_inv_sub_bytes_engine;

  localparam logic [127:0] V1 = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] R1 = 128'h52096AD53036A538BF40A39E81F3D7FB;
  localparam logic [127:0] V2 = 128'h0F0E0D0C0B0A09080706050403020100;
  localparam logic [127:0] R2 = 128'hFBD7F3819EA340BF38A53630D56A0952;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] in_state = '0;
  logic         in_ready;
  logic         out_valid;
  logic [127:0] out_state;
  logic         busy;

  logic         sw_in_valid = 1'b0;
  logic         sw_out_ready = 1'b1;
  logic [127:0] sw_in_state = '0;
  logic [3:0]   sw_in_ready;
  logic [3:0]   sw_out_valid;
  logic [3:0]   sw_busy;
  logic [127:0] sw_out_state [4];

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int acc_cnt = 0;
  int pop_cnt = 0;
  int last_acc = 0;
  logic [127:0] last_pop = '0;
  logic [127:0] exp_q[$];
  logic prev_ov = 1'b0;

  // clock / reset-free clock generation
  always #5 clk = ~clk;

  inv_sub_bytes_engine #(.BYTES_PER_CYCLE(4)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state),
    .busy      (busy)
  );

  for (genvar g = 0; g < 4; g++) begin : g_sw
    localparam int NN = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 8 : 16;
    inv_sub_bytes_engine #(.BYTES_PER_CYCLE(NN)) u_sw (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (sw_in_valid),
      .in_ready  (sw_in_ready[g]),
      .in_state  (sw_in_state),
      .out_valid (sw_out_valid[g]),
      .out_ready (sw_out_ready),
      .out_state (sw_out_state[g]),
      .busy      (sw_busy[g])
    );
  end

  function automatic int sw_n(input int g);
    return (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 8 : 16;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // reference model: plain polynomial arithmetic, inverse found by search
  function automatic logic [7:0] gf_mul8(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic [7:0] x;
    r = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    end
    return r;
  endfunction

  function automatic logic [7:0] model_byte(input logic [7:0] a);
    logic [7:0] b;
    b = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
    if (b == 8'h00) return 8'h00;
    for (int y = 1; y < 256; y++) begin
      if (gf_mul8(b, 8'(y)) == 8'h01) return 8'(y);
    end
    return 8'h00;
  endfunction

  function automatic logic [127:0] model_state(input logic [127:0] s);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = model_byte(s[127-8*i -: 8]);
    return r;
  endfunction

  // scoreboard: push on acceptance, pop on output handshake, flush on reset
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (in_valid && in_ready) begin
        exp_q.push_back(model_state(in_state));
        acc_cnt++;
        last_acc = cyc;
      end
      if (out_valid && out_ready) begin
        last_pop = out_state;
        pop_cnt++;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
    end
  end

  // compare every cycle the output is meaningful
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (!prev_ov) check("latency", 128'(cyc - last_acc), 128'(4));
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL out_unexpected: out_state %h with no block pending", out_state);
      end else begin
        check("out_state", out_state, exp_q[0]);
      end
    end
    prev_ov = rst_n && out_valid;
  end

  // driver tasks
  task automatic wait_acc(input int target, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (acc_cnt >= target) ok = 1'b1;
    end
    if (!ok) check({name, "_accept_timeout"}, 128'(acc_cnt), 128'(target));
  endtask

  task automatic wait_pops(input int target, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (pop_cnt >= target) ok = 1'b1;
    end
    if (!ok) check({name, "_output_timeout"}, 128'(pop_cnt), 128'(target));
  endtask

  task automatic send_block(input logic [127:0] data, input string name);
    int start;
    @(negedge clk);
    start    = acc_cnt;
    in_state = data;
    in_valid = 1'b1;
    wait_acc(start + 1, name);
    in_valid = 1'b0;
  endtask

  task automatic run_block(input logic [127:0] data, input logic [127:0] req, input string name);
    int p0;
    p0 = pop_cnt;
    out_ready = 1'b1;
    send_block(data, name);
    wait_pops(p0 + 1, name);
    check(name, last_pop, req);
  endtask

  task automatic wait_valid(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (out_valid) ok = 1'b1;
    end
    if (!ok) check({name, "_valid_timeout"}, 128'(out_valid), 128'(1));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rel_cyc;
    int s;
    int p0;
    int a1;
    int a2;
    bit seen [4];
    int lat [4];
    logic [127:0] outs [4];
    logic [127:0] held;

    // pin the model against known inverse S-box entries
    check("model_00", 128'(model_byte(8'h00)), 128'h52);
    check("model_01", 128'(model_byte(8'h01)), 128'h09);
    check("model_63", 128'(model_byte(8'h63)), 128'h00);
    check("model_7c", 128'(model_byte(8'h7C)), 128'h01);
    check("model_16", 128'(model_byte(8'h16)), 128'hFF);
    check("model_ed", 128'(model_byte(8'hED)), 128'h53);
    check("model_v1", model_state(V1), R1);

    // reset with in_valid held high: nothing may be accepted
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_state = V1;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 128'(in_ready), 128'(1));
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_out_state", out_state, 128'h0);

    // first edge with rst_n high accepts the pending block
    out_ready = 1'b1;
    rst_n     = 1'b1;
    rel_cyc   = cyc;
    wait_acc(1, "first");
    in_valid = 1'b0;
    check("first_accept_edge", 128'(last_acc), 128'(rel_cyc + 1));
    wait_pops(1, "first");
    check("vector1", last_pop, R1);

    run_block({16{8'h63}}, {16{8'h00}}, "all_63");
    run_block({16{8'h7C}}, {16{8'h01}}, "all_7c");
    run_block({16{8'h16}}, {16{8'hFF}}, "all_16");
    run_block({16{8'hED}}, {16{8'h53}}, "all_ed");

    // backpressure in DONE
    out_ready = 1'b0;
    send_block(V2, "bp");
    wait_valid("bp");
    held = out_state;
    check("bp_result", held, R2);
    in_valid = 1'b1;
    in_state = V1;
    s = acc_cnt;
    repeat (10) begin
      @(negedge clk);
      check("bp_out_valid", 128'(out_valid), 128'(1));
      check("bp_out_state", out_state, held);
      check("bp_in_ready", 128'(in_ready), 128'(0));
    end
    check("bp_no_accept", 128'(acc_cnt), 128'(s));
    in_valid = 1'b0;
    p0 = pop_cnt;
    out_ready = 1'b1;
    wait_pops(p0 + 1, "bp");
    check("bp_pop", last_pop, R2);

    // reset at the second RUN edge
    send_block(V1, "midrun");
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrun_in_ready", 128'(in_ready), 128'(1));
    check("midrun_out_valid", 128'(out_valid), 128'(0));
    check("midrun_out_state", out_state, 128'h0);
    check("midrun_busy", 128'(busy), 128'(0));
    rst_n = 1'b1;
    run_block(V2, R2, "after_reset");

    // back-to-back blocks with in_valid held high
    out_ready = 1'b1;
    p0 = pop_cnt;
    @(negedge clk);
    s = acc_cnt;
    in_state = V1;
    in_valid = 1'b1;
    wait_acc(s + 1, "b2b_a");
    a1 = last_acc;
    in_state = V2;
    wait_acc(s + 2, "b2b_b");
    a2 = last_acc;
    in_valid = 1'b0;
    check("b2b_period", 128'(a2 - a1), 128'(6));
    wait_pops(p0 + 2, "b2b");
    check("b2b_second", last_pop, R2);

    // lane-count sweep on the first vector
    for (int g = 0; g < 4; g++) begin
      seen[g] = 1'b0;
      lat[g]  = 0;
      outs[g] = '0;
    end
    @(negedge clk);
    sw_in_state = V1;
    sw_in_valid = 1'b1;
    @(negedge clk);
    sw_in_valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      for (int g = 0; g < 4; g++) begin
        if (sw_out_valid[g] && !seen[g]) begin
          seen[g] = 1'b1;
          lat[g]  = k;
          outs[g] = sw_out_state[g];
        end
      end
    end
    for (int g = 0; g < 4; g++) begin
      check($sformatf("sweep_n%0d_latency", sw_n(g)), 128'(lat[g]), 128'(16 / sw_n(g)));
      check($sformatf("sweep_n%0d_state", sw_n(g)), outs[g], R1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/inv_sub_bytes_engine.md
# inv_sub_bytes_engine

Byte-serial AES InvSubBytes unit for the decryption datapath: accepts a 128-bit state over a valid/ready handshake and applies the inverse S-box to every byte, BYTES_PER_CYCLE bytes per clock. Each inverse S-box is the inverse affine transform followed by multiplicative inversion in GF(2^8). Inversion uses the composite-field GF((2^4)^2) method that the encryption-side SubBytes path also uses. The unit sits between the inverse ShiftRows and AddRoundKey stages of the decryption round.

## Interface
- BYTES_PER_CYCLE, default 4. Number of inverse S-box lanes. Legal values: 1, 2, 4, 8, 16. Any other value is an elaboration error.
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  in_state is valid.
- in_ready  output  1  engine can accept a block.
- in_state  input  128  ciphertext-side state. Byte i = in_state[127-8i -: 8], so byte 0 is the MSB byte.
- out_valid  output  1  out_state holds a finished block.
- out_ready  input  1  downstream accepts out_state.
- out_state  output  128  InvSubBytes(in_state), using the same byte ordering.
- busy  output  1  high in RUN and DONE.

## Operation
- FSM states:
  - IDLE: in_ready=1. On in_valid && in_ready, capture in_state into the state register, clear the lane counter and go to RUN.
  - RUN: each cycle, replace bytes cnt*N .. cnt*N+N-1 in place with InvSbox(byte), where N = BYTES_PER_CYCLE. Then increment cnt. When cnt == 16/N-1, go to DONE.
  - DONE: out_valid=1 and out_state is the state register. On out_ready, go to IDLE.
- in_ready is high only in IDLE. A block is never accepted in RUN or DONE, and in_valid is ignored there.
- out_state is held stable while out_valid && !out_ready. Outside DONE, out_state still drives the register, but consumers must not use it.
- Inverse S-box for byte a:
  - b = rotl(a,1) ^ rotl(a,3) ^ rotl(a,6) ^ 8'h05.
  - Result = b^-1 in GF(2^8) modulo x^8+x^4+x^3+x+1, with 0^-1 = 0.
  - Inversion is done in the composite field: isomorphic map in, GF(2^4) square, multiply-by-lambda, GF(2^4) multiply and GF(2^4) inverse, then inverse map out.
- Counter width is clog2(16/N), with a minimum of 1 bit. When N=16, RUN lasts exactly one cycle.
- Reset: rst_n low at a clock edge forces IDLE, cnt=0, state register=0, out_valid=0, in_ready=1 (after the edge), busy=0. This applies in any state, including mid-RUN and DONE. The partial block is discarded and no output is produced for it.

## Timing
- Acceptance edge is T. RUN occupies edges T+1 .. T+16/N. out_valid is high after edge T+16/N.
  - With N=4: accept at T, out_valid visible from T+4.
- Earliest next acceptance is the edge after the out_ready edge, because IDLE must be re-entered first. Minimum period is 16/N+2 cycles.
- The inverse S-box path is combinational within one RUN cycle, with no internal pipeline registers.
- Reset values: in_ready=1, out_valid=0, busy=0, out_state=128'h0.
- in_valid asserted together with reset is ignored. Acceptance can happen no earlier than the first edge with rst_n high.

## Structure
- Shared package aes_pkg:
  - AES_STATE_BYTES=16
  - AES_INV_AFFINE_C=8'h05
  - state enum {IDLE, RUN, DONE}
  - byte-index helper for the MSB-first ordering
- One sub-module, inv_sbox (8-bit in, 8-bit out, combinational). It contains the inverse affine stage and the composite-field inversion.
- The engine instantiates BYTES_PER_CYCLE copies of inv_sbox via generate, and muxes lane inputs by cnt.

## Test plan
- N=4, in_state=128'h000102030405060708090A0B0C0D0E0F, out_ready=1 → out_state=128'h52096AD53036A538BF40A39E81F3D7FB. out_valid rises exactly 4 cycles after acceptance.
- N=4, in_state = all bytes 0x63 → all 0x00. in_state = all 0x7C → all 0x01. in_state = all 0x16 → all 0xFF. in_state = all 0xED → all 0x53.
- Backpressure: hold out_ready=0 for 10 cycles in DONE. out_valid and out_state must stay stable, in_ready must stay 0, and an asserted in_valid must not be accepted.
- Reset mid-RUN: assert rst_n=0 at the second RUN edge → after that edge in_ready=1, out_valid=0, out_state=0. A new block sent afterwards completes correctly.
- Back-to-back: in_valid held high with two blocks and out_ready=1 → second acceptance exactly 16/N+2 cycles after the first, and both results are correct.
- Parameter sweep with N=1, 2, 8, 16 on the first vector → identical out_state. Latency equals 16/N cycles.
